// File: rtl/aes_decrypt_pipe_param.sv
// ---------------------------------------------------------------------------
// aes_decrypt_pipe_param
//
// Fully unrolled AES inverse cipher. The pipeline has NR+1 register stages.
// Stage 0 applies the initial AddRoundKey. Each later stage applies one full
// inverse round. Every stage carries a valid bit and a sideband tag. All
// stages advance together whenever the output register is empty or is being
// consumed. Bubbles stay in place and are not squeezed out.
//
// Parameters
//   NR     number of rounds: 10, 12 or 14 (AES-128/192/256)
//   TAG_W  width of the sideband tag
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     input block offered
//   in_ready     pipe accepts the block this cycle (global advance)
//   data_in      ciphertext block
//   in_tag       tag travelling with the block
//   round_keys   expanded encryption schedule; slice k = round key k
//   flush        synchronous discard of every in-flight block
//   out_valid    plaintext block available
//   out_ready    consumer accepts the output block
//   data_out     plaintext block
//   out_tag      tag of the block on data_out
//   occupancy    number of blocks in flight
//   busy         occupancy is nonzero
// ---------------------------------------------------------------------------
module aes_decrypt_pipe_param #(
    parameter int NR    = 14,
    parameter int TAG_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              data_in,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [(NR+1)*128-1:0]     round_keys,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              data_out,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(NR+2)-1:0]   occupancy,
    output logic                      busy
);

    localparam int OCC_W = $clog2(NR+2);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (9, 11, 13 or 14) built from xtime terms.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? b  : 8'h00);
    endfunction

    // State byte (row r, column c) lives at bits [127-8*(r+4c) -: 8].
    // Row r is rotated right by r positions, then each byte is substituted.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] =
                    INV_SBOX[s[127-8*(row+4*((c-row+4)%4)) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            r[119-32*c -: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            r[111-32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            r[103-32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
        end
        return r;
    endfunction

    logic [NR:0]      vld;
    logic [127:0]     dat [0:NR];
    logic [TAG_W-1:0] tag [0:NR];
    logic [127:0]     nxt [0:NR];
    logic             adv;
    logic             in_hs;
    logic             out_hs;

    assign out_valid = vld[NR];
    assign data_out  = dat[NR];
    assign out_tag   = tag[NR];

    // One advance signal moves the whole pipe, so a stalled output freezes
    // every stage and the output register stays stable.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign in_hs    = in_valid && adv;
    assign out_hs   = out_valid && out_ready;
    assign busy     = (occupancy != '0);

    // Round keys are consumed in reverse order: stage i uses key NR-i.
    // The last stage omits InvMixColumns.
    always_comb begin
        for (int i = 0; i <= NR; i++) begin
            nxt[i] = '0;
        end
        nxt[0] = data_in ^ round_keys[128*NR +: 128];
        for (int i = 1; i <= NR; i++) begin
            if (i == NR) begin
                nxt[i] = inv_shift_sub(dat[i-1]) ^ round_keys[128*(NR-i) +: 128];
            end else begin
                nxt[i] = inv_mix(inv_shift_sub(dat[i-1]) ^ round_keys[128*(NR-i) +: 128]);
            end
        end
    end

    // Data and tags shift whenever the pipe advances. Valid bits follow the
    // same shift, but flush wipes them regardless of the advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i <= NR; i++) begin
                dat[i] <= '0;
                tag[i] <= '0;
            end
        end else begin
            if (adv) begin
                dat[0] <= nxt[0];
                tag[0] <= in_tag;
                for (int i = 1; i <= NR; i++) begin
                    dat[i] <= nxt[i];
                    tag[i] <= tag[i-1];
                end
            end
            if (flush) begin
                vld <= '0;
            end else if (adv) begin
                vld <= {vld[NR-1:0], in_hs};
            end
        end
    end

    // A simultaneous input and output handshake leaves the count unchanged.
    // Flush wins over both handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_hs && !out_hs) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_hs && out_hs) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_decrypt_pipe_param.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_pipe_param
//
// Directed bench for aes_decrypt_pipe_param. Two instances are used: dut_a
// with NR=14 and dut_b with NR=10. Round keys are expanded here from the
// cipher keys, using a forward S-box derived arithmetically (GF inverse plus
// affine map). Expected plaintexts are the published test vectors.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_pipe_param;

    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
    logic [127:0]      a_data_in, a_data_out;
    logic [7:0]        a_in_tag, a_out_tag;
    logic [3:0]        a_occ;
    logic [15*128-1:0] a_keys;

    logic              b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
    logic [127:0]      b_data_in, b_data_out;
    logic [7:0]        b_in_tag, b_out_tag;
    logic [3:0]        b_occ;
    logic [11*128-1:0] b_keys;

    int checks = 0;
    int errors = 0;

    logic [7:0]        sbox [256];
    logic [31:0]       w [60];
    logic [15*128-1:0] rk_tmp;

    aes_decrypt_pipe_param #(.NR(14), .TAG_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .in_tag(a_in_tag), .round_keys(a_keys), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
        .out_tag(a_out_tag), .occupancy(a_occ), .busy(a_busy)
    );

    aes_decrypt_pipe_param #(.NR(10), .TAG_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .in_tag(b_in_tag), .round_keys(b_keys), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
        .out_tag(b_out_tag), .occupancy(b_occ), .busy(b_busy)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox;
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        rk_tmp = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) rk_tmp[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_data_out !== 128'h0) begin errors++; $display("[TB] FAIL rst_data_out: got %h expected 0", a_data_out); end
        checks++; if (a_out_tag !== 8'h00) begin errors++; $display("[TB] FAIL rst_out_tag: got %h expected 00", a_out_tag); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL rst_occupancy: got %0d expected 0", a_occ); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_out_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_b_in_ready: got %b expected 1", b_in_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL post_rst_occupancy: got %0d expected 0", a_occ); end
    endtask

    task automatic test_vector_256;
        int cycles;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_data_in   = CT256;
        a_in_tag    = 8'h5A;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL v256_in_ready: got %b expected 1", a_in_ready); end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        cycles = 1;
        while (!a_out_valid && cycles < 40) begin tick(); cycles++; end
        checks++; if (cycles !== 15) begin errors++; $display("[TB] FAIL v256_latency: got %0d expected 15", cycles); end
        checks++; if (a_data_out !== PT) begin errors++; $display("[TB] FAIL v256_data: got %h expected %h", a_data_out, PT); end
        checks++; if (a_out_tag !== 8'h5A) begin errors++; $display("[TB] FAIL v256_tag: got %h expected 5a", a_out_tag); end
        checks++; if (a_occ !== 4'd1) begin errors++; $display("[TB] FAIL v256_occupancy: got %0d expected 1", a_occ); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("[TB] FAIL v256_busy: got %b expected 1", a_busy); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL v256_drained: got %b expected 0", a_out_valid); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL v256_occ_empty: got %0d expected 0", a_occ); end
    endtask

    task automatic test_vector_128(input logic [127:0] key, input logic [127:0] ct,
                                   input logic [127:0] pt, input logic [7:0] tg);
        int cycles;
        expand_key({key, 128'h0}, 4, 10);
        b_keys      = rk_tmp[11*128-1:0];
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_data_in   = ct;
        b_in_tag    = tg;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        cycles = 1;
        while (!b_out_valid && cycles < 40) begin tick(); cycles++; end
        checks++; if (cycles !== 11) begin errors++; $display("[TB] FAIL v128_latency: got %0d expected 11", cycles); end
        checks++; if (b_data_out !== pt) begin errors++; $display("[TB] FAIL v128_data: got %h expected %h", b_data_out, pt); end
        checks++; if (b_out_tag !== tg) begin errors++; $display("[TB] FAIL v128_tag: got %h expected %h", b_out_tag, tg); end
        tick();
    endtask

    task automatic test_back_to_back;
        int sent, rcvd, cyc;
        logic stalled;
        sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
        while (rcvd < 40 && cyc < 2000) begin
            a_in_valid  = (sent < 40);
            a_data_in   = CT256;
            a_in_tag    = 8'(sent);
            a_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++; if (a_occ > 4'd15) begin errors++; $display("[TB] FAIL b2b_occ_bound: got %0d expected <= 15", a_occ); end
            if (stalled) begin
                checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall_hold: got %b expected 1", a_out_valid); end
            end
            if (a_out_valid) begin
                checks++; if (a_out_tag !== 8'(rcvd)) begin errors++; $display("[TB] FAIL b2b_tag: got %0d expected %0d", a_out_tag, rcvd); end
                checks++; if (a_data_out !== PT) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", a_data_out, PT); end
            end
            stalled = a_out_valid && !a_out_ready;
            if (a_in_valid && a_in_ready) sent++;
            if (a_out_valid && a_out_ready) rcvd++;
            @(posedge clk);
            #1;
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        checks++; if (rcvd !== 40) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 40", rcvd); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL b2b_occ_end: got %0d expected 0", a_occ); end
    endtask

    task automatic test_fill_stall;
        int acc, expt, cyc;
        acc = 0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            a_in_valid = 1'b1;
            a_data_in  = CT256;
            a_in_tag   = 8'(100 + acc);
            #1;
            if (a_in_valid && a_in_ready) acc++;
            @(posedge clk);
            #1;
        end
        checks++; if (acc !== 15) begin errors++; $display("[TB] FAIL fill_accepted: got %0d expected 15", acc); end
        checks++; if (a_occ !== 4'd15) begin errors++; $display("[TB] FAIL fill_occupancy: got %0d expected 15", a_occ); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready: got %b expected 0", a_in_ready); end
        checks++; if (a_out_tag !== 8'd100) begin errors++; $display("[TB] FAIL fill_head_tag: got %0d expected 100", a_out_tag); end
        a_out_ready = 1'b1;
        a_in_tag    = 8'd115;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pulse_in_ready: got %b expected 1", a_in_ready); end
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        checks++; if (a_occ !== 4'd15) begin errors++; $display("[TB] FAIL pulse_occupancy: got %0d expected 15", a_occ); end
        checks++; if (a_out_tag !== 8'd101) begin errors++; $display("[TB] FAIL pulse_next_tag: got %0d expected 101", a_out_tag); end
        a_out_ready = 1'b1;
        expt = 101;
        cyc  = 0;
        while (expt <= 115 && cyc < 100) begin
            if (a_out_valid) begin
                checks++; if (a_out_tag !== 8'(expt)) begin errors++; $display("[TB] FAIL drain_tag: got %0d expected %0d", a_out_tag, expt); end
                checks++; if (a_data_out !== PT) begin errors++; $display("[TB] FAIL drain_data: got %h expected %h", a_data_out, PT); end
                expt++;
            end
            tick();
            cyc++;
        end
        checks++; if (expt !== 116) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 116", expt); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL drain_occ: got %0d expected 0", a_occ); end
    endtask

    task automatic test_flush;
        int cycles;
        logic seen;
        a_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_data_in  = CT256;
            a_in_tag   = 8'(200 + i);
            tick();
        end
        a_in_tag = 8'd207;
        a_flush  = 1'b1;
        #1;
        checks++; if (a_occ !== 4'd7) begin errors++; $display("[TB] FAIL flush_pre_occ: got %0d expected 7", a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", a_in_ready); end
        @(posedge clk);
        #1;
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d expected 0", a_occ); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", a_busy); end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (a_out_valid) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost: got %b expected 0", seen); end
        a_in_valid = 1'b1;
        a_in_tag   = 8'd210;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        cycles = 1;
        while (!a_out_valid && cycles < 40) begin tick(); cycles++; end
        checks++; if (cycles !== 15) begin errors++; $display("[TB] FAIL flush_new_latency: got %0d expected 15", cycles); end
        checks++; if (a_out_tag !== 8'd210) begin errors++; $display("[TB] FAIL flush_new_tag: got %0d expected 210", a_out_tag); end
        tick();
    endtask

    task automatic test_reset_mid;
        int cycles;
        logic seen;
        a_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1'b1;
            a_data_in  = CT256;
            a_in_tag   = 8'(50 + i);
            tick();
        end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_streaming: got %b expected 1", a_out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_data_out !== 128'h0) begin errors++; $display("[TB] FAIL rmid_data_out: got %h expected 0", a_data_out); end
        checks++; if (a_out_tag !== 8'h00) begin errors++; $display("[TB] FAIL rmid_out_tag: got %h expected 00", a_out_tag); end
        checks++; if (a_occ !== 4'd0) begin errors++; $display("[TB] FAIL rmid_occupancy: got %0d expected 0", a_occ); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", a_in_ready); end
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_out_valid) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ghost: got %b expected 0", seen); end
        a_in_valid = 1'b1;
        a_in_tag   = 8'd90;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        cycles = 1;
        while (!a_out_valid && cycles < 40) begin tick(); cycles++; end
        checks++; if (a_out_tag !== 8'd90) begin errors++; $display("[TB] FAIL rmid_first_tag: got %0d expected 90", a_out_tag); end
        checks++; if (a_data_out !== PT) begin errors++; $display("[TB] FAIL rmid_first_data: got %h expected %h", a_data_out, PT); end
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1; a_data_in = '0; a_in_tag = '0;
        b_in_valid  = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1; b_data_in = '0; b_in_tag = '0;
        build_sbox();
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        a_keys = rk_tmp;
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        b_keys = rk_tmp[11*128-1:0];

        test_reset();
        test_vector_256();
        test_vector_128(128'h000102030405060708090a0b0c0d0e0f, CT128, PT, 8'h11);
        test_vector_128(128'h2b7e151628aed2a6abf7158809cf4f3c,
                        128'h3925841d02dc09fbdc118597196a0b32,
                        128'h3243f6a8885a308d313198a2e0370734, 8'h22);
        test_back_to_back();
        test_fill_stall();
        test_flush();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_pipe_param.md
AES_DECRYPT_PIPE_PARAM -- requirements
Module: aes_decrypt_pipe_param

Interface
REQ-001 SHALL have parameter NR, default 14; number of AES rounds; legal values 10, 12, 14 only (AES-128/192/256).
REQ-002 SHALL have parameter TAG_W, default 8; width of the sideband tag carried alongside each block.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  input block offered.
REQ-006 SHALL have port in_ready  out  1  pipe accepts the input block this cycle.
REQ-007 SHALL have port data_in  in  128  ciphertext block.
REQ-008 SHALL have port in_tag  in  TAG_W  sideband tag for the block.
REQ-009 SHALL have port round_keys  in  (NR+1)*128  expanded key schedule; slice k = bits [128k+127:128k] is encryption round key k.
REQ-010 SHALL have port flush  in  1  synchronous discard of all in-flight blocks.
REQ-011 SHALL have port out_valid  out  1  plaintext block available.
REQ-012 SHALL have port out_ready  in  1  consumer accepts the output block.
REQ-013 SHALL have port data_out  out  128  plaintext block.
REQ-014 SHALL have port out_tag  out  TAG_W  tag of the block on data_out.
REQ-015 SHALL have port occupancy  out  clog2(NR+2)  number of blocks in flight.
REQ-016 SHALL have port busy  out  1  high when occupancy is nonzero.

Function
REQ-017 SHALL implement NR+1 registered stages, each with a valid bit, a 128-bit data register and a TAG_W tag register.
REQ-018 Stage 0 SHALL compute data_in XOR key slice NR.
REQ-019 Stage i, for 1 <= i <= NR-1, SHALL compute InvShiftRows, then InvSubBytes, then XOR key slice NR-i, then InvMixColumns.
REQ-020 Stage NR SHALL compute InvShiftRows, then InvSubBytes, then XOR key slice 0, with no InvMixColumns; its registers drive data_out, out_tag and out_valid.
REQ-021 SHALL use the global advance signal adv = !out_valid || out_ready; all stages shift together when adv=1 and all hold when adv=0.
REQ-022 SHALL drive in_ready = adv, combinationally; a block is accepted when in_valid && in_ready.
REQ-023 On advance, stage 0 valid SHALL load (in_valid && in_ready), and stage i valid SHALL load stage i-1 valid.
REQ-024 Bubbles SHALL NOT be compressed.
REQ-025 Unstalled latency SHALL be exactly NR+1 cycles from acceptance to out_valid.
REQ-026 Throughput SHALL be one block per cycle while out_ready=1.
REQ-027 out_valid and data_out SHALL stay stable while out_valid && !out_ready.
REQ-028 Blocks SHALL leave in acceptance order, each with its tag unchanged.
REQ-029 occupancy SHALL increment on input handshake only, decrement on output handshake only, and stay unchanged when both occur in the same cycle.
REQ-030 occupancy SHALL never exceed NR+1.
REQ-031 flush=1 SHALL clear all stage valids and occupancy on the next edge.
REQ-032 flush SHALL take priority over a same-cycle input handshake (that block is dropped) and over a same-cycle output handshake (no double decrement).
REQ-033 in_ready SHALL follow REQ-022 regardless of flush.
REQ-034 round_keys SHALL be held stable by the source while busy=1; output is unspecified if it changes mid-flight.
REQ-035 Inverse S-box SHALL be a combinational lookup; no RAM.

Reset
REQ-036 When rst_n=0, SHALL asynchronously clear all stage valid, data and tag registers to 0.
REQ-037 During and after reset, outputs SHALL be out_valid=0, data_out=0, out_tag=0, occupancy=0, busy=0, in_ready=1.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight blocks, with no output handshake afterwards until new input arrives.

Verification
REQ-039 NR=14, key 000102..1f expanded, data_in 8ea2b7ca516745bfeafc49904b496089, tag 0x5A, out_ready=1 -> data_out 00112233445566778899aabbccddeeff, out_tag 0x5A, exactly 15 cycles after acceptance.
REQ-040 NR=10, key 000102..0f expanded, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff after 11 cycles.
REQ-041 NR=14, 40 back-to-back blocks with tags 0..39 and random out_ready -> all 40 out in order with correct tags and values, occupancy <= 15, no output change while stalled.
REQ-042 Fill pipe with out_ready=0 -> occupancy reaches 15, then in_ready=0; one out_ready pulse -> exactly one block out and occupancy stays 15 if in_valid=1.
REQ-043 flush asserted with 7 blocks in flight and in_valid=1 -> next cycle occupancy=0, out_valid=0, and no flushed or dropped block ever appears.
REQ-044 rst_n pulsed low mid-stream for under one clock period -> all outputs at reset values immediately; the first output after reset is the first block accepted after reset.
